// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: shifts a qualified stream into a PAT_W-bit history and
// compares it against NUM_PAT programmable slots. Define SEQDET_MASK_EN for per-slot don't-care masks.
`timescale 1ns/1ps
module seq_pattern_detector #(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             overlap,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_sel,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_en,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  output logic             match,
  output logic [ID_W-1:0]  match_id,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] history,
  output logic             primed
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  pat_q [NUM_PAT];
  logic [NUM_PAT-1:0] en_q;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0]  mask_q [NUM_PAT];
`endif
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  next_hist_c;
  logic [PAT_W-1:0]  hist_nxt_c;
  logic [FILL_W-1:0] fill_nxt_c;
  logic [ID_W-1:0]   hit_id_c;
  logic              hit_any_c;
  logic              cfg_ok_c;
  logic              full_c;
  logic              event_c;

  // Slot compare against the history as it will look after this bit; lowest index wins.
  always_comb begin
    next_hist_c = {history[PAT_W-2:0], bit_in};
    cfg_ok_c    = cfg_we && (32'(cfg_sel) < NUM_PAT);
    full_c      = (32'(fill) + 32'd1) >= PAT_W;
    hit_any_c   = 1'b0;
    hit_id_c    = '0;
    for (int i = int'(NUM_PAT) - 1; i >= 0; i--) begin
`ifdef SEQDET_MASK_EN
      if (en_q[i] && ((next_hist_c & ~mask_q[i]) == (pat_q[i] & ~mask_q[i]))) begin
`else
      if (en_q[i] && (next_hist_c == pat_q[i])) begin
`endif
        hit_any_c = 1'b1;
        hit_id_c  = ID_W'(i);
      end
    end
    event_c = bit_valid && hit_any_c && full_c && !cfg_ok_c && !clear;
  end

  // Next history/fill: a non-overlapping match or a slot rewrite restarts the fill.
  always_comb begin
    hist_nxt_c = history;
    fill_nxt_c = fill;
    if (bit_valid) begin
      if (event_c && !overlap) begin
        hist_nxt_c = '0;
        fill_nxt_c = '0;
      end else begin
        hist_nxt_c = next_hist_c;
        fill_nxt_c = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
      end
    end
    if (cfg_ok_c) begin
      fill_nxt_c = '0;
    end
    if (clear) begin
      hist_nxt_c = '0;
      fill_nxt_c = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history     <= '0;
      fill        <= '0;
      primed      <= 1'b0;
      match       <= 1'b0;
      match_id    <= '0;
      match_count <= '0;
    end else begin
      history <= hist_nxt_c;
      fill    <= fill_nxt_c;
      primed  <= (fill_nxt_c == FILL_W'(PAT_W));
      match   <= event_c;
      if (clear) begin
        match_count <= '0;
      end else if (event_c) begin
        match_id <= hit_id_c;
        if (match_count != {CNT_W{1'b1}}) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

  // Pattern slot storage; writes are blocked while clear is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q <= '0;
      for (int i = 0; i < int'(NUM_PAT); i++) begin
        pat_q[i] <= '0;
`ifdef SEQDET_MASK_EN
        mask_q[i] <= '0;
`endif
      end
    end else if (cfg_ok_c && !clear) begin
      for (int i = 0; i < int'(NUM_PAT); i++) begin
        if (cfg_sel == ID_W'(i)) begin
          pat_q[i] <= cfg_pattern;
          en_q[i]  <= cfg_en;
`ifdef SEQDET_MASK_EN
          mask_q[i] <= cfg_mask;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus randomized stream checked every cycle
// against an arithmetic reference model; a second instance uses a 2-bit counter for saturation.
`timescale 1ns/1ps
module tb_seq_pattern_detector;
  localparam int unsigned PW  = 4;
  localparam int unsigned NP  = 2;
  localparam int unsigned IW  = 1;
  localparam int unsigned CW  = 8;
  localparam int unsigned CW2 = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic bit_valid = 1'b0, bit_in = 1'b0, overlap = 1'b1, clear = 1'b0;
  logic cfg_we = 1'b0, cfg_en = 1'b0;
  logic [IW-1:0] cfg_sel = '0;
  logic [PW-1:0] cfg_pattern = '0;

  logic match, match2, primed, primed2;
  logic [IW-1:0] match_id, match_id2;
  logic [CW-1:0] match_count;
  logic [CW2-1:0] match_count2;
  logic [PW-1:0] history, history2;

  always #5 clock = ~clock;

  seq_pattern_detector #(.PAT_W(PW), .NUM_PAT(NP), .ID_W(IW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .overlap(overlap),
    .clear(clear), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern), .cfg_en(cfg_en),
    .match(match), .match_id(match_id), .match_count(match_count), .history(history), .primed(primed));

  seq_pattern_detector #(.PAT_W(PW), .NUM_PAT(NP), .ID_W(IW), .CNT_W(CW2)) dut2 (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .overlap(overlap),
    .clear(clear), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern), .cfg_en(cfg_en),
    .match(match2), .match_id(match_id2), .match_count(match_count2), .history(history2),
    .primed(primed2));

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  // Reference model: integers for history, fill and an unbounded match count.
  int m_hist = 0, m_fill = 0, m_cnt = 0, m_id = 0;
  bit m_match = 1'b0;
  int m_pat [NP];
  bit m_en [NP];
  int nh_c, hit_c;
  bit wr_c;

  always_comb begin
    nh_c  = ((m_hist * 2) + int'(bit_in)) % (1 << PW);
    wr_c  = cfg_we && (int'(cfg_sel) < int'(NP));
    hit_c = -1;
    if (m_fill + 1 >= int'(PW)) begin
      for (int i = int'(NP) - 1; i >= 0; i--) begin
        if (m_en[i] && m_pat[i] == nh_c) hit_c = i;
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_hist <= 0; m_fill <= 0; m_cnt <= 0; m_id <= 0; m_match <= 1'b0;
      for (int i = 0; i < int'(NP); i++) begin
        m_pat[i] <= 0;
        m_en[i]  <= 1'b0;
      end
    end else if (clear) begin
      m_hist <= 0; m_fill <= 0; m_cnt <= 0; m_match <= 1'b0;
    end else begin
      m_match <= 1'b0;
      if (bit_valid) begin
        if (hit_c >= 0 && !wr_c) begin
          m_match <= 1'b1;
          m_id    <= hit_c;
          m_cnt   <= m_cnt + 1;
        end
        if (hit_c >= 0 && !wr_c && !overlap) begin
          m_hist <= 0;
          m_fill <= 0;
        end else begin
          m_hist <= nh_c;
          m_fill <= (m_fill + 1 > int'(PW)) ? int'(PW) : m_fill + 1;
        end
      end
      if (wr_c) begin
        m_fill <= 0;
        m_pat[cfg_sel] <= int'(cfg_pattern);
        m_en[cfg_sel]  <= cfg_en;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(negedge clock) begin
    if (run) begin
      chk("match", int'(match), int'(m_match));
      chk("match_id", int'(match_id), m_id);
      chk("match_count", int'(match_count), sat(m_cnt, CW));
      chk("history", int'(history), m_hist);
      chk("primed", int'(primed), int'(m_fill == int'(PW)));
      chk("match2", int'(match2), int'(m_match));
      chk("match_count2", int'(match_count2), sat(m_cnt, CW2));
      chk("history2", int'(history2), m_hist);
    end
  end

  task automatic send(input bit b);
    bit_valid = 1'b1; bit_in = b;
    @(negedge clock);
    bit_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] v);
    for (int k = 3; k >= 0; k--) send(v[k]);
  endtask

  task automatic cfg(input int sel, input logic [3:0] p, input bit e);
    cfg_we = 1'b1; cfg_sel = IW'(sel); cfg_pattern = p; cfg_en = e;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_match", int'(match), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_history", int'(history), 0);
    chk("rst_primed", int'(primed), 0);
    reset = 1'b1;
    run = 1'b1;
    @(negedge clock);

    // Basic detection with two enabled slots
    overlap = 1'b1;
    cfg(0, 4'b1101, 1'b1);
    cfg(1, 4'b1100, 1'b1);
    send4(4'b1101);
    chk("t1_match", int'(match), 1);
    chk("t1_id", int'(match_id), 0);
    chk("t1_count", int'(match_count), 1);
    chk("t1_history", int'(history), 13);
    chk("t1_primed", int'(primed), 1);
    @(negedge clock);
    chk("t1_pulse_end", int'(match), 0);

    // Overlap versus restart
    do_clear();
    cfg(0, 4'b1010, 1'b1);
    cfg(1, 4'b0000, 1'b0);
    send4(4'b1010);
    chk("t2_ov_m4", int'(match), 1);
    send(1'b1);
    send(1'b0);
    chk("t2_ov_m6", int'(match), 1);
    chk("t2_ov_count", int'(match_count), 2);
    do_clear();
    overlap = 1'b0;
    send4(4'b1010);
    chk("t2_nov_m4", int'(match), 1);
    send(1'b1);
    send(1'b0);
    chk("t2_nov_m6", int'(match), 0);
    chk("t2_nov_count", int'(match_count), 1);
    chk("t2_nov_hist", int'(history), 2);

    // Two slots hit at once: lowest index, single increment
    do_clear();
    overlap = 1'b1;
    cfg(0, 4'b1111, 1'b1);
    cfg(1, 4'b1111, 1'b1);
    send4(4'b1111);
    chk("t3_id", int'(match_id), 0);
    chk("t3_count", int'(match_count), 1);
    cfg(0, 4'b1111, 1'b0);
    send4(4'b1111);
    chk("t3_id_slot1", int'(match_id), 1);
    chk("t3_count2", int'(match_count), 2);

    // Config write coinciding with the completing bit
    do_clear();
    cfg(0, 4'b1001, 1'b1);
    cfg(1, 4'b0000, 1'b0);
    send(1'b1); send(1'b0); send(1'b0);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_pattern = 4'b0000; cfg_en = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clock);
    cfg_we = 1'b0; bit_valid = 1'b0;
    chk("t4_nomatch", int'(match), 0);
    chk("t4_primed", int'(primed), 0);
    chk("t4_hist", int'(history), 9);
    send4(4'b1001);
    chk("t4_match", int'(match), 1);

    // Counter saturation on the 2-bit instance, then clear
    do_clear();
    cfg(0, 4'b1111, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      send(1'b1);
      if (k >= 4) chk("t5_pulse", int'(match2), 1);
    end
    chk("t5_count2_sat", int'(match_count2), 3);
    chk("t5_count", int'(match_count), 5);
    do_clear();
    chk("t5_clr_count2", int'(match_count2), 0);
    chk("t5_clr_hist", int'(history), 0);
    send4(4'b1111);
    chk("t5_kept_pattern", int'(match2), 1);

    // Asynchronous reset mid-pattern
    cfg(0, 4'b1101, 1'b1);
    send(1'b1); send(1'b1); send(1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_match", int'(match), 0);
    chk("t6_count", int'(match_count), 0);
    chk("t6_hist", int'(history), 0);
    chk("t6_primed", int'(primed), 0);
    @(negedge clock);
    reset = 1'b1;
    send4(4'b1101);
    chk("t6_disabled", int'(match), 0);

    // Randomized stream
    for (int c = 0; c < 6000; c++) begin
      bit_valid   = ($urandom_range(0, 9) < 7);
      bit_in      = 1'($urandom);
      cfg_we      = ($urandom_range(0, 49) == 0);
      cfg_sel     = IW'($urandom);
      cfg_pattern = PW'($urandom);
      cfg_en      = ($urandom_range(0, 3) != 0);
      clear       = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) == 0) overlap = 1'($urandom);
      if (c == 3000) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
      @(negedge clock);
    end
    bit_valid = 1'b0; cfg_we = 1'b0; clear = 1'b0;
    @(negedge clock);
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit, two-pattern detector FSM used on the board demo.
- Shifts a qualified serial stream into a PAT_W-bit history and compares it against NUM_PAT run-time programmable patterns.
- Reports a one-cycle match pulse, the matching slot ID and a saturating match count.
- Overlap and non-overlap detection modes; history is exported for display logic such as the HEX shifter.

Parameters:
- PAT_W, 4: pattern/history length in bits (>=2).
- NUM_PAT, 2: number of pattern slots (>=1).
- ID_W, 1: width of slot index, must be >= clog2(NUM_PAT) and >= 1.
- CNT_W, 8: match counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- bit_valid  input  1  qualifies bit_in for this cycle.
- bit_in  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after a match.
- clear  input  1  synchronous clear of history, fill and count.
- cfg_we  input  1  pattern slot write strobe.
- cfg_sel  input  ID_W  slot index for the write.
- cfg_pattern  input  PAT_W  pattern value; bit PAT_W-1 is the first bit received.
- cfg_en  input  1  slot enable written with the pattern.
- match  output  1  one-cycle pulse on detection.
- match_id  output  ID_W  lowest matching slot index, held until the next match.
- match_count  output  CNT_W  total matches, saturating.
- history  output  PAT_W  last PAT_W accepted bits; bit 0 is the newest.
- primed  output  1  fill has reached PAT_W.

Behaviour:
- Reset values: history=0, fill=0, primed=0, match=0, match_id=0, match_count=0, all patterns=0, all slot enables=0.
- Accept: on a bit_valid cycle, history <= {history[PAT_W-2:0], bit_in}; fill increments, saturating at PAT_W; primed = (fill==PAT_W).
- Compare: uses next_hist (the shifted value including the current bit_in). A slot hits when it is enabled, next_hist == pattern, and fill+1 >= PAT_W.
- Match registered with 1-cycle latency: match is high the cycle after the edge that samples the last pattern bit.
- match_id = lowest-index hit slot; match_count increments once per match event, never once per slot.
- Counter saturation: at all-ones, match_count holds and match still pulses.
- No bit_valid: history, fill and match are unchanged, except match, which deasserts after one cycle.
- overlap=1: fill is unchanged on match, so the next bit can complete another match.
- overlap=0: on a match, fill <= 0 and history <= 0. The next match needs PAT_W fresh bits.
- cfg_we: writes the pattern and enable of slot cfg_sel; cfg_sel >= NUM_PAT is ignored. Any valid write sets fill <= 0 and primed <= 0.
- cfg_we and bit_valid in the same cycle: the bit shifts into history, fill <= 0 and no match is raised. The new pattern is used from the next cycle.
- clear: history, fill and match_count go to 0 and match is suppressed; patterns are kept. clear has priority over cfg_we and bit_valid.
- Reset mid-stream: all state, including patterns, returns to reset values immediately and asynchronously. match drops at once.

Optional Feature:
- SEQDET_MASK_EN defined: adds input cfg_mask [PAT_W-1:0], written with each slot (reset 0). A slot hits when (next_hist & ~mask) == (pattern & ~mask); a mask bit of 1 means don't-care.
- Undefined: no cfg_mask port; exact compare only.

Test Plan:
- Program slot0=1101 en, slot1=1100 en, overlap=1; stream 1,1,0,1 -> match pulses 1 cycle after 4th bit, match_id=0, match_count=1, history=4'b1101.
- overlap=1, slot0=1010; stream 1,0,1,0,1,0 -> matches after bits 4 and 6, count=2. Repeat with overlap=0 -> one match after bit 4 and none after bit 6; count=1.
- Both slots=1111 enabled; stream 1,1,1,1 -> match_id=0, count=1 (single increment).
- Enabled slot0=1001, stream 1,0,0 with cfg_we to slot1 on the cycle of the 4th bit (1) -> no match; primed=0; a further 4 bits 1,0,0,1 -> match.
- CNT_W=2, 5 matches -> match_count sticks at 3, match still pulses each time. Then clear -> count=0, history=0, patterns still match.
- Reset asserted mid-pattern (after 1,1,0) -> all outputs 0 immediately; after release, stream 1 -> no match (slots disabled).
